// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: drives a variable-latency data memory over req/ack, stalls the
// upstream pipeline while an access is outstanding, resolves branches and tracks errors.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   EX_Mem_MemRead,
  input  logic                   EX_Mem_MemWrite,
  input  logic                   EX_Mem_Branch,
  input  logic                   EX_Mem_Zero,
  input  logic [63:0]            EX_Mem_ALU_Rslt,
  input  logic [63:0]            EX_Mem_ForwardB_MUX,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [63:0]            mem_addr,
  output logic [63:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [63:0]            mem_rdata,
  output logic                   stall,
  output logic [63:0]            rdata,
  output logic                   rdata_valid,
  output logic                   PCSrc,
  output logic                   flush,
  input  logic                   err_clr,
  output logic                   misalign_err,
  output logic                   timeout_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] tcnt, tcnt_nxt;
  logic            req_nxt, we_nxt, rvalid_nxt;
  logic [63:0]     addr_nxt, wdata_nxt, rdata_nxt;
  logic            stall_int, mis_evt, to_evt;
  logic            access, misaligned;

  assign access     = EX_Mem_MemRead | EX_Mem_MemWrite;
  assign misaligned = access & (EX_Mem_ALU_Rslt[2:0] != 3'd0);

  // Reset gating keeps the pipeline-control outputs quiet while the block is held in reset.
  assign stall = stall_int & ~reset;
  assign PCSrc = EX_Mem_Branch & EX_Mem_Zero & ~stall_int & ~reset;
  assign flush = PCSrc;

  // Next-state and next values of the registered memory-side outputs
  always_comb begin
    state_nxt  = state;
    tcnt_nxt   = tcnt;
    req_nxt    = mem_req;
    we_nxt     = mem_we;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    rdata_nxt  = rdata;
    rvalid_nxt = 1'b0;
    stall_int  = 1'b0;
    mis_evt    = 1'b0;
    to_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          mis_evt = 1'b1;
        end else if (access) begin
          stall_int = 1'b1;
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          we_nxt    = EX_Mem_MemWrite;
          addr_nxt  = EX_Mem_ALU_Rslt;
          wdata_nxt = EX_Mem_ForwardB_MUX;
          tcnt_nxt  = '0;
        end
      end
      WAIT: begin
        stall_int = 1'b1;
        if (mem_ack) begin
          req_nxt    = 1'b0;
          rdata_nxt  = mem_we ? rdata : mem_rdata;
          rvalid_nxt = ~mem_we;
          state_nxt  = DONE;
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          req_nxt    = 1'b0;
          to_evt     = 1'b1;
          rdata_nxt  = '0;
          rvalid_nxt = ~mem_we;
          state_nxt  = DONE;
        end else begin
          tcnt_nxt = tcnt + TO_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      mem_req     <= req_nxt;
      mem_we      <= we_nxt;
      mem_addr    <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      rdata       <= rdata_nxt;
      rdata_valid <= rvalid_nxt;
      // A new error event takes priority over a coincident clear
      if (mis_evt)      misalign_err <= 1'b1;
      else if (err_clr) misalign_err <= 1'b0;
      if (to_evt)       timeout_err  <= 1'b1;
      else if (err_clr) timeout_err  <= 1'b0;
      if (stall_int && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: hand-filled combinational vectors, directed multi-cycle
// sequences and randomized transactions checked against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_Mem_MemRead, EX_Mem_MemWrite, EX_Mem_Branch, EX_Mem_Zero;
  logic [63:0] EX_Mem_ALU_Rslt, EX_Mem_ForwardB_MUX;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        stall, rdata_valid, PCSrc, flush, err_clr, misalign_err, timeout_err;
  logic [31:0] stall_cnt;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .STALL_CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .EX_Mem_MemRead(EX_Mem_MemRead), .EX_Mem_MemWrite(EX_Mem_MemWrite),
    .EX_Mem_Branch(EX_Mem_Branch), .EX_Mem_Zero(EX_Mem_Zero),
    .EX_Mem_ALU_Rslt(EX_Mem_ALU_Rslt), .EX_Mem_ForwardB_MUX(EX_Mem_ForwardB_MUX),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .PCSrc(PCSrc), .flush(flush), .err_clr(err_clr),
    .misalign_err(misalign_err), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  logic [63:0] m_rdata;
  logic        m_mis_err, m_to_err;
  longint      m_stall_cnt;

  typedef struct packed {
    logic       rd, wr, br, z;
    logic [2:0] lo;
    logic       exp_stall, exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    EX_Mem_MemRead = 1'b0; EX_Mem_MemWrite = 1'b0; EX_Mem_Branch = 1'b0; EX_Mem_Zero = 1'b0;
    EX_Mem_ALU_Rslt = '0; EX_Mem_ForwardB_MUX = '0; err_clr = 1'b0;
  endtask

  // One aligned access; ack in WAIT cycle k, or never when k > TIMEOUT
  task automatic run_access(input bit rd, input bit wr, input logic [63:0] addr,
                            input logic [63:0] wd, input int k, input logic [63:0] ad);
    bit to, is_wr, hold_ok;
    int nwait, stall_n, req_n;
    is_wr = wr;
    to    = (k > int'(TIMEOUT));
    nwait = to ? int'(TIMEOUT) : k;
    @(posedge clk); #1;
    idle_inputs();
    EX_Mem_MemRead = rd; EX_Mem_MemWrite = wr;
    EX_Mem_ALU_Rslt = addr; EX_Mem_ForwardB_MUX = wd; mem_ack = 1'b0;
    #1;
    stall_n = int'(stall); req_n = int'(mem_req); hold_ok = 1'b1;
    for (int c = 1; c <= nwait; c++) begin
      @(posedge clk); #1;
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? ad : {$urandom, $urandom};
      #1;
      stall_n += int'(stall); req_n += int'(mem_req);
      if (mem_addr !== addr || mem_we !== is_wr || (is_wr && mem_wdata !== wd)) hold_ok = 1'b0;
    end
    @(posedge clk); #1;
    mem_ack = to; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    m_stall_cnt += nwait + 1;
    if (to) begin m_to_err = 1'b1; m_rdata = '0; end
    else if (!is_wr) m_rdata = ad;
    check("stall_cycles", 64'(stall_n), 64'(nwait + 1));
    check("req_cycles", 64'(req_n), 64'(nwait));
    check("req_hold", 64'(hold_ok), 64'd1);
    check("done_stall", 64'(stall), 64'd0);
    check("done_req", 64'(mem_req), 64'd0);
    check("rdata_valid", 64'(rdata_valid), 64'(!is_wr));
    check("rdata", rdata, m_rdata);
    check("timeout_err", 64'(timeout_err), 64'(m_to_err));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("post_valid", 64'(rdata_valid), 64'd0);
    check("post_stall", 64'(stall), 64'd0);
    check("post_req", 64'(mem_req), 64'd0);
    check("post_rdata", rdata, m_rdata);
    mem_ack = 1'b0;
  endtask

  task automatic run_misalign(input bit rd, input bit wr, input logic [63:0] addr, input bit clr);
    @(posedge clk); #1;
    idle_inputs();
    EX_Mem_MemRead = rd; EX_Mem_MemWrite = wr; EX_Mem_ALU_Rslt = addr; err_clr = clr;
    #1;
    check("mis_stall", 64'(stall), 64'd0);
    m_mis_err = 1'b1;
    if (clr) m_to_err = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("mis_err", 64'(misalign_err), 64'(m_mis_err));
    check("mis_req", 64'(mem_req), 64'd0);
    check("mis_valid", 64'(rdata_valid), 64'd0);
    check("mis_to_err", 64'(timeout_err), 64'(m_to_err));
  endtask

  task automatic run_clear();
    @(posedge clk); #1;
    idle_inputs(); err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    #1;
    m_mis_err = 1'b0; m_to_err = 1'b0;
    check("clr_mis", 64'(misalign_err), 64'd0);
    check("clr_to", 64'(timeout_err), 64'd0);
  endtask

  task automatic run_branch(input bit z);
    @(posedge clk); #1;
    idle_inputs(); EX_Mem_Branch = 1'b1; EX_Mem_Zero = z;
    #1;
    check("br_pcsrc", 64'(PCSrc), 64'(z));
    check("br_flush", 64'(flush), 64'(z));
    idle_inputs();
  endtask

  function automatic logic [63:0] rand_addr(input bit aligned);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[2:0] = aligned ? 3'd0 : 3'($urandom_range(1, 7));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   op, k;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};

    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    idle_inputs();
    m_rdata = '0; m_mis_err = 1'b0; m_to_err = 1'b0; m_stall_cnt = 0;
    #3;
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_pcsrc", 64'(PCSrc), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Directed sequences
    run_access(1'b1, 1'b0, 64'h100, 64'h0, 3, 64'hDEADBEEF_CAFEF00D);
    run_access(1'b0, 1'b1, 64'h208, 64'h1234, 1, 64'h0);
    run_misalign(1'b1, 1'b0, 64'h103, 1'b0);
    run_clear();
    run_access(1'b1, 1'b0, 64'h400, 64'h0, TIMEOUT + 1, 64'h0);
    run_misalign(1'b0, 1'b1, 64'h1001, 1'b1);
    run_clear();
    run_branch(1'b1);
    run_branch(1'b0);

    // Combinational vectors, applied in IDLE and withdrawn before the next edge
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      idle_inputs();
      EX_Mem_MemRead = vecs[i].rd; EX_Mem_MemWrite = vecs[i].wr;
      EX_Mem_Branch = vecs[i].br; EX_Mem_Zero = vecs[i].z;
      EX_Mem_ALU_Rslt = {61'h40, vecs[i].lo};
      #1;
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d_pcsrc", i), 64'(PCSrc), 64'(vecs[i].exp_pc));
      check($sformatf("vec%0d_flush", i), 64'(flush), 64'(vecs[i].exp_pc));
      idle_inputs();
    end

    // Reset in the middle of a WAIT
    @(posedge clk); #1;
    idle_inputs(); EX_Mem_MemRead = 1'b1; EX_Mem_ALU_Rslt = 64'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_req", 64'(mem_req), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_addr", mem_addr, 64'd0);
    check("arst_cnt", 64'(stall_cnt), 64'd0);
    idle_inputs();
    m_rdata = '0; m_mis_err = 1'b0; m_to_err = 1'b0; m_stall_cnt = 0;
    @(negedge clk); reset = 1'b0;
    run_access(1'b1, 1'b0, 64'h500, 64'h0, 2, 64'h0123_4567_89AB_CDEF);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 5));
      k  = ($urandom_range(0, 5) == 0) ? int'(TIMEOUT) + 1 : int'($urandom_range(1, 5));
      case (op)
        0: run_access(1'b1, 1'b0, rand_addr(1'b1), {$urandom, $urandom}, k, {$urandom, $urandom});
        1: run_access(1'b0, 1'b1, rand_addr(1'b1), {$urandom, $urandom}, k, {$urandom, $urandom});
        2: run_access(1'b1, 1'b1, rand_addr(1'b1), {$urandom, $urandom}, k, {$urandom, $urandom});
        3: run_misalign(1'($urandom), 1'b1, rand_addr(1'b0), 1'($urandom));
        4: run_clear();
        default: run_branch(1'($urandom));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage sequencer for the 5-stage 64-bit pipeline. Sits after the EX/MEM pipeline register and drives a variable-latency data memory over a req/ack handshake. While an access is outstanding it stalls the upstream pipeline registers. It also resolves branches (PCSrc/flush), flags misaligned and timed-out accesses, and counts stall cycles.

Parameters:
TIMEOUT, 16, max WAIT cycles without mem_ack before the access is aborted (>=2)
STALL_CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
EX_Mem_MemRead  in  1  load in MEM stage
EX_Mem_MemWrite  in  1  store in MEM stage
EX_Mem_Branch  in  1  branch in MEM stage
EX_Mem_Zero  in  1  ALU zero flag from EX/MEM
EX_Mem_ALU_Rslt  in  64  effective address
EX_Mem_ForwardB_MUX  in  64  store data
mem_req  out  1  memory request (registered)
mem_we  out  1  1 = write, valid while mem_req
mem_addr  out  64  latched address
mem_wdata  out  64  latched store data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  64  read data, valid with mem_ack
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
rdata  out  64  registered load data to MEM/WB
rdata_valid  out  1  rdata valid this cycle
PCSrc  out  1  take branch target (EX_Mem_Adder)
flush  out  1  squash IF/ID and ID/EX
err_clr  in  1  clears sticky error flags
misalign_err  out  1  sticky: misaligned access seen
timeout_err  out  1  sticky: access timed out
stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset values (async, immediate): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rdata_valid=0, both error flags=0, stall_cnt=0, timeout counter=0. Combinational outputs evaluate accordingly: stall=0, PCSrc=0, flush=0.
- access = EX_Mem_MemRead | EX_Mem_MemWrite.
- misaligned = access & (EX_Mem_ALU_Rslt[2:0] != 0). All accesses are doublewords.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access & ~misaligned: stall=1 (combinational, same cycle). Next cycle: state=WAIT, mem_req=1, mem_we=EX_Mem_MemWrite, mem_addr/mem_wdata latched, timeout counter=0.
  - Both MemRead and MemWrite set: treated as a write.
  - misaligned: no request, no stall; misalign_err set next edge. The instruction proceeds; rdata_valid=0.
- WAIT:
  - stall=1; mem_req, mem_addr, mem_wdata, mem_we held stable.
  - mem_ack=1: mem_req=0 next edge; rdata=mem_rdata for reads, unchanged for writes; state=DONE.
  - No ack: counter increments. If counter==TIMEOUT-1 with no ack, then at the next edge mem_req=0, timeout_err=1, rdata=0, state=DONE.
  - A late mem_ack arriving in DONE or IDLE is ignored.
- DONE:
  - stall=0; rdata_valid=1 for exactly this cycle if the access was a read, else 0. State returns to IDLE.
  - EX/MEM advances at the end of DONE, so IDLE never re-issues the same instruction.
- Access latency: ack in the k-th WAIT cycle gives k+1 stall cycles, then DONE. Minimum total occupancy is 3 cycles (IDLE-stall, WAIT, DONE).
- Branch: PCSrc = flush = EX_Mem_Branch & EX_Mem_Zero & ~stall. Both are combinational.
- stall_cnt increments on every clock edge where stall=1 and saturates at all-ones.
- Error flags:
  - err_clr=1 clears both flags at the next edge.
  - If err_clr coincides with a new error event, the set wins.
- Reset mid-access: mem_req drops immediately; the outstanding access is abandoned. The memory side must tolerate this.

Test Plan:
- Load at addr 0x100, ack on the 3rd WAIT cycle with rdata 0xDEADBEEF_CAFEF00D -> stall high 4 cycles; mem_req high 3 cycles with we=0 and addr=0x100; DONE cycle has rdata_valid=1 and rdata=0xDEADBEEF_CAFEF00D; stall_cnt=4.
- Store addr 0x208, data 0x1234, immediate ack -> mem_we=1, mem_wdata=0x1234; stall 2 cycles; rdata_valid stays 0.
- Load at 0x103 -> no mem_req, stall=0, misalign_err=1 next cycle; err_clr pulse -> 0.
- Load with no ack and TIMEOUT=16 -> mem_req high exactly 16 cycles, then DONE with rdata=0 and rdata_valid=1; timeout_err=1; ack injected afterwards causes no state change.
- Branch=1, Zero=1, no access -> PCSrc=flush=1 same cycle. Branch=1, Zero=0 -> both 0.
- Reset asserted in WAIT -> mem_req, stall, and state clear asynchronously. After release, a new load sequences normally.
